// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing the write port of the asynchronous FIFO among
// NUM_REQ packet sources in the write clock domain. A grant is held for a
// whole packet (ends on the transfer carrying last) or until MAX_BURST words
// have been transferred (MAX_BURST = 0 means no cap). The FIFO's full flag
// is honoured combinationally: no write and no ready while full.
//
// Ports
//   w_clk_i      in   write-domain clock, rising edge
//   rst_n_i      in   asynchronous active-low reset
//   src_req_i    in   [NUM_REQ]   per-source word valid
//   src_last_i   in   [NUM_REQ]   per-source end-of-packet marker
//   src_data_i   in   [NUM_REQ*DATA_WIDTH] source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   src_ready_o  out  [NUM_REQ]   per-source ready (transfer = req & ready)
//   w_full_i     in   FIFO full flag from write control
//   w_req_o      out  FIFO write request
//   w_data_o     out  [DATA_WIDTH] FIFO write data
//   gnt_o        out  [NUM_REQ]   registered one-hot grant, zero when idle
//   busy_o       out  high while a grant is active
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          w_clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            src_req_i,
  input  logic [NUM_REQ-1:0]            src_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data_i,
  output logic [NUM_REQ-1:0]            src_ready_o,
  input  logic                          w_full_i,
  output logic                          w_req_o,
  output logic [DATA_WIDTH-1:0]         w_data_o,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          busy_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  // Counter value at which the next transfer closes a capped grant.
  localparam logic [CW-1:0] CAP_LAST = (MAX_BURST == 0) ? '0 : CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       burst_cnt_q, burst_cnt_d;

  logic                req_g;
  logic                last_g;
  logic [DATA_WIDTH-1:0] data_g;
  logic                hi_found, lo_found;
  logic [PW-1:0]       hi_idx, lo_idx;
  logic                sel_found;
  logic [PW-1:0]       sel_idx;
  logic                xfer;
  logic                cap_hit;

  // Lanes of the currently granted source. A compare per source keeps the
  // mux valid for any NUM_REQ, including non-powers of two.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx_q == PW'(k)) begin
        req_g  = src_req_i[k];
        last_g = src_last_i[k];
        data_g = src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pick: lowest requester at or above rr_ptr if any ("hi"),
  // otherwise the lowest requester overall, which is the wrap-around case.
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (src_req_i[k]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(k);
        if (PW'(k) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PW'(k);
        end
      end
    end
    sel_found = lo_found;
    sel_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Outputs. gnt_q is zero outside GRANT, so ready needs no state qualifier.
  assign busy_o      = (state_q == ST_GRANT);
  assign gnt_o       = gnt_q;
  assign src_ready_o = w_full_i ? '0 : gnt_q;
  assign w_req_o     = busy_o & req_g & ~w_full_i;
  assign w_data_o    = busy_o ? data_g : '0;
  assign xfer        = w_req_o;
  assign cap_hit     = (MAX_BURST != 0) && (burst_cnt_q == CAP_LAST);

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d     = ST_GRANT;
          idx_d       = sel_idx;
          gnt_d       = NUM_REQ'(1) << sel_idx;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // No transfer (source bubble or FIFO full) holds everything.
        if (xfer) begin
          if (last_g || cap_hit) begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            burst_cnt_d = '0;
            // Explicit wrap: NUM_REQ need not be a power of two.
            rr_ptr_d    = (idx_q == LAST_IDX) ? '0 : idx_q + PW'(1);
          end else if (burst_cnt_q != '1) begin
            // Saturating: only reachable as a limit when MAX_BURST is 0.
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Drives fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4) from
// per-source word queues. A behavioural model (owner index, words in this
// grant, next-first pointer, modulo arithmetic) predicts every output each
// cycle. Directed scenarios add explicit expectations on top, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            w_clk_i = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    src_req_i;
  logic [N-1:0]    src_last_i;
  logic [N*DW-1:0] src_data_i;
  logic [N-1:0]    src_ready_o;
  logic            w_full_i;
  logic            w_req_o;
  logic [DW-1:0]   w_data_o;
  logic [N-1:0]    gnt_o;
  logic            busy_o;

  fifo_write_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .w_clk_i    (w_clk_i),
    .rst_n_i    (rst_n_i),
    .src_req_i  (src_req_i),
    .src_last_i (src_last_i),
    .src_data_i (src_data_i),
    .src_ready_o(src_ready_o),
    .w_full_i   (w_full_i),
    .w_req_o    (w_req_o),
    .w_data_o   (w_data_o),
    .gnt_o      (gnt_o),
    .busy_o     (busy_o)
  );

  always #5 w_clk_i = ~w_clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Source side: each source presents the head of its queue ({last, data})
  // and holds it until transferred.
  logic [DW:0]  pend[N][$];
  bit           presented[N];
  bit           stall_src[N];
  logic [N-1:0] xfer_prev;

  // Behavioural model state.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  // Last sampled DUT outputs, for directed checks.
  logic [N-1:0]  last_gnt, last_ready;
  logic          last_busy, last_wreq;
  logic [DW-1:0] last_wdata;
  logic [DW-1:0] wlog[$];

  task automatic push_pkt(input int k, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d;
      d = base + DW'(i);
      pend[k].push_back({(i == len - 1), d});
    end
  endtask

  task automatic drive_sources();
    for (int k = 0; k < N; k++) begin
      if (xfer_prev[k]) begin
        pend[k].delete(0);
        presented[k] = 1'b0;
      end
      if (!presented[k] && pend[k].size() > 0 && !stall_src[k]) presented[k] = 1'b1;
      src_req_i[k] = presented[k];
      if (presented[k]) begin
        src_last_i[k]          = pend[k][0][DW];
        src_data_i[k*DW +: DW] = pend[k][0][DW-1:0];
      end else begin
        src_last_i[k]          = 1'b0;
        src_data_i[k*DW +: DW] = DW'($urandom);
      end
    end
    xfer_prev = '0;
  endtask

  // One clock cycle: predict, compare at negedge, advance model, step to
  // just after the next rising edge.
  task automatic cycle();
    logic [N-1:0]  e_gnt, e_ready;
    logic          e_busy, e_wreq;
    logic [DW-1:0] e_data;
    @(negedge w_clk_i);
    e_busy  = (m_owner >= 0);
    e_gnt   = '0;
    e_ready = '0;
    e_wreq  = 1'b0;
    e_data  = '0;
    if (e_busy) begin
      e_gnt[m_owner] = 1'b1;
      if (!w_full_i) e_ready[m_owner] = 1'b1;
      e_wreq = src_req_i[m_owner] && !w_full_i;
      e_data = src_data_i[m_owner*DW +: DW];
    end
    last_gnt   = gnt_o;
    last_ready = src_ready_o;
    last_busy  = busy_o;
    last_wreq  = w_req_o;
    last_wdata = w_data_o;
    check("cyc_gnt",   gnt_o,       e_gnt);
    check("cyc_busy",  busy_o,      e_busy);
    check("cyc_ready", src_ready_o, e_ready);
    check("cyc_wreq",  w_req_o,     e_wreq);
    if (e_wreq) check("cyc_wdata", w_data_o, e_data);
    if (w_req_o) wlog.push_back(w_data_o);
    xfer_prev = e_ready & src_req_i;
    if (m_owner < 0) begin
      for (int j = 0; j < N; j++) begin
        int c = (m_ptr + j) % N;
        if (m_owner < 0 && src_req_i[c]) m_owner = c;
      end
      m_cnt = 0;
    end else if (e_wreq) begin
      m_cnt++;
      if (src_last_i[m_owner] || (MB != 0 && m_cnt == MB)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    @(posedge w_clk_i);
    #1;
  endtask

  task automatic tick();
    drive_sources();
    cycle();
  endtask

  task automatic do_reset();
    rst_n_i    = 1'b0;
    w_full_i   = 1'b0;
    src_req_i  = '0;
    src_last_i = '0;
    src_data_i = '0;
    xfer_prev  = '0;
    for (int k = 0; k < N; k++) begin
      pend[k].delete();
      presented[k] = 1'b0;
      stall_src[k] = 1'b0;
    end
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    wlog.delete();
    repeat (2) @(posedge w_clk_i);
    @(negedge w_clk_i);
    rst_n_i = 1'b1;
    @(posedge w_clk_i);
    #1;
  endtask

  initial begin
    logic [N-1:0]  rr_exp[12];
    logic [DW-1:0] exp_w[$];

    rst_n_i    = 1'b1;
    w_full_i   = 1'b0;
    src_req_i  = '0;
    src_last_i = '0;
    src_data_i = '0;
    xfer_prev  = '0;
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rst_gnt",   gnt_o,       0);
    check("rst_busy",  busy_o,      0);
    check("rst_ready", src_ready_o, 0);
    check("rst_wreq",  w_req_o,     0);
    do_reset();

    // Single source: src1 sends A1, A2, A3(last).
    push_pkt(1, 3, 8'hA1);
    tick();
    check("ss_idle_gnt", last_gnt, 4'b0000);
    tick();
    check("ss_gnt",   last_gnt,   4'b0010);
    check("ss_wreq1", last_wreq,  1);
    check("ss_data1", last_wdata, 8'hA1);
    tick();
    check("ss_data2", last_wdata, 8'hA2);
    tick();
    check("ss_wreq3", last_wreq,  1);
    check("ss_data3", last_wdata, 8'hA3);
    tick();
    check("ss_end_gnt",  last_gnt,  4'b0000);
    check("ss_end_busy", last_busy, 0);

    // Round-robin: every source streams 1-word packets.
    do_reset();
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 6; p++) push_pkt(k, 1, DW'(k * 16 + p));
    rr_exp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2};
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("rr_gnt%0d", i), last_gnt, rr_exp[i]);
    end

    // Full stall mid-packet of src2.
    do_reset();
    push_pkt(2, 6, 8'h20);
    repeat (3) tick();
    w_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fs_wreq",  last_wreq,  0);
      check("fs_ready", last_ready, 0);
      check("fs_gnt",   last_gnt,   4'b0100);
    end
    w_full_i = 1'b0;
    tick();
    check("fs_resume_wreq", last_wreq,  1);
    check("fs_resume_data", last_wdata, 8'h22);
    tick();
    check("fs_cap_data", last_wdata, 8'h23);
    tick();
    check("fs_cap_end", last_gnt, 4'b0000);
    repeat (6) tick();

    // Burst cap: src0 10 words, src3 two 2-word packets.
    do_reset();
    push_pkt(0, 10, 8'h10);
    push_pkt(3, 2, 8'h30);
    push_pkt(3, 2, 8'h32);
    repeat (22) tick();
    for (int i = 0; i < 4; i++) exp_w.push_back(DW'(8'h10 + i));
    exp_w.push_back(8'h30); exp_w.push_back(8'h31);
    for (int i = 4; i < 8; i++) exp_w.push_back(DW'(8'h10 + i));
    exp_w.push_back(8'h32); exp_w.push_back(8'h33);
    exp_w.push_back(8'h18); exp_w.push_back(8'h19);
    check("bc_count", wlog.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
      check($sformatf("bc_word%0d", i), wlog[i], exp_w[i]);

    // Source bubble: src1 drops req for 3 cycles mid-packet.
    do_reset();
    push_pkt(1, 6, 8'h50);
    tick();
    tick();
    push_pkt(0, 1, 8'h70);
    push_pkt(2, 1, 8'h72);
    stall_src[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sb_gnt",   last_gnt,   4'b0010);
      check("sb_ready", last_ready, 4'b0010);
      check("sb_wreq",  last_wreq,  0);
      check("sb_busy",  last_busy,  1);
    end
    stall_src[1] = 1'b0;
    tick();
    check("sb_resume", last_wdata, 8'h51);
    repeat (15) tick();

    // Reset mid-packet of src2, after src0 moved the pointer to 1.
    do_reset();
    push_pkt(0, 1, 8'h80);
    push_pkt(2, 6, 8'h60);
    repeat (5) tick();
    rst_n_i = 1'b0;
    #2;
    check("mr_gnt",   gnt_o,       0);
    check("mr_busy",  busy_o,      0);
    check("mr_ready", src_ready_o, 0);
    check("mr_wreq",  w_req_o,     0);
    check("mr_wdata", w_data_o,    0);
    do_reset();
    push_pkt(0, 1, 8'h90);
    push_pkt(2, 1, 8'h92);
    tick();
    tick();
    check("mr_after_gnt",  last_gnt,   4'b0001);
    check("mr_after_data", last_wdata, 8'h90);
    repeat (4) tick();

    // Randomized traffic with bubbles and full.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (pend[k].size() == 0 && $urandom_range(0, 3) == 0)
          push_pkt(k, int'($urandom_range(1, 9)), DW'($urandom));
        stall_src[k] = ($urandom_range(0, 3) == 0);
      end
      w_full_i = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO among `NUM_REQ` packet sources in the write clock domain. It grants one source at a time for a whole packet, or up to a word cap, and forwards that source's words to the FIFO write port. It honours the FIFO's registered full flag and back-pressures every source through a per-source ready. It sits directly in front of the FIFO write-control logic and drives its write request.

## Interface

**Parameters**

- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, default 8: width of one data word.
- `MAX_BURST`, default 16: maximum words per grant. A value of 0 means unlimited; the grant ends only on `last`.

**Ports**

- `w_clk_i` in, 1: write-domain clock; all logic is on its rising edge.
- `rst_n_i` in, 1: reset, asynchronous, active-low.
- `src_req_i` in, NUM_REQ: per-source valid; a word is present.
- `src_last_i` in, NUM_REQ: per-source flag marking the word as the final word of its packet.
- `src_data_i` in, NUM_REQ*DATA_WIDTH: source k's word occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `src_ready_o` out, NUM_REQ: per-source ready; a transfer occurs when req and ready are both high.
- `w_full_i` in, 1: FIFO full flag from write control.
- `w_req_o` out, 1: FIFO write request.
- `w_data_o` out, DATA_WIDTH: FIFO write data.
- `gnt_o` out, NUM_REQ: registered one-hot grant, or all zeros when none.
- `busy_o` out, 1: high while in state GRANT.

## Operation

**States**

- IDLE:
  - If `src_req_i` is nonzero, select the first requester at or after `rr_ptr`, searching upward with wrap-around.
  - Load `gnt_o`, clear `burst_cnt`, and go to GRANT at the next edge.
  - If `src_req_i` is zero, stay in IDLE.
- GRANT, with granted index g:
  - `src_ready_o[g] = ~w_full_i`. Every other ready bit is 0.
  - `w_req_o = src_req_i[g] & ~w_full_i`.
  - `w_data_o` = slice g of `src_data_i`. It is combinational, and valid whenever `w_req_o` is high.
  - Each transfer increments `burst_cnt`.
  - Transfer with `src_last_i[g]` = 1, or transfer with `burst_cnt == MAX_BURST-1` when `MAX_BURST` is not 0: go to IDLE, clear `gnt_o`, and set `rr_ptr = (g+1) mod NUM_REQ`.
  - `src_req_i[g]` low: hold the grant. A grant is never revoked mid-packet except by the burst cap.

**Arithmetic and width rules**

- `burst_cnt` is `$clog2(MAX_BURST+1)` bits wide, or 1 bit when `MAX_BURST` is 0. It never wraps.
- `rr_ptr` is `$clog2(NUM_REQ)` bits wide. The wrap from `NUM_REQ-1` to 0 is explicit, because `NUM_REQ` need not be a power of two.

**Full flag**

- When `w_full_i` is 1, the arbiter produces no write and no ready, and holds its state and counters.
- The arbiter never asserts `w_req_o` while `w_full_i` is 1, so no word is lost or duplicated.

**Burst cap**

- A cap-terminated grant leaves the source mid-packet. The source keeps its req high and re-arbitrates.
- Downstream consumers must tolerate interleaving at cap boundaries. They can avoid it by setting `MAX_BURST` to 0 or sizing it at least as large as the largest packet.

**Reset values**

- `gnt_o` = 0, `busy_o` = 0, `src_ready_o` = 0, `w_req_o` = 0.
- `rr_ptr` = 0, `burst_cnt` = 0, state = IDLE.
- Reset asserted mid-packet aborts the grant immediately. Partial packets already in the FIFO are not recalled.

## Timing

- Grant latency: req rises in cycle n while IDLE; `gnt_o` and ready are visible in cycle n+1.
- First FIFO write occurs in cycle n+1 if `w_full_i` is 0.
- Throughput inside a grant is one word per cycle while not full.
- Inter-grant gap is exactly 1 IDLE cycle. The packet end at cycle m gives IDLE at m+1 and the next grant at m+2.
- `w_full_i` is sampled combinationally. A write in cycle t that fills the FIFO is reflected by write control in `w_full_i` at t+1, and ready drops in that same cycle.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins. Every active source is served within `NUM_REQ` grants.
- Sources must hold data, req and last stable until the transfer occurs.

## Test plan

- **Single source:** after reset, src1 sends a 3-word packet 0xA1, 0xA2, 0xA3 with last on 0xA3.
  - `gnt_o` = 0010 one cycle after req.
  - `w_req_o` is high for 3 consecutive cycles with those data.
  - `gnt_o` = 0 and `busy_o` = 0 after the last word.
- **Round-robin:** all 4 sources request 1-word packets continuously. The grant order is 0, 1, 2, 3, 0, 1, with exactly 1 idle cycle between grants.
- **Full stall:** force `w_full_i` = 1 for 5 cycles mid-packet of src2.
  - `w_req_o` = 0 and `src_ready_o` = 0 throughout.
  - The grant is held and `burst_cnt` is unchanged.
  - On release, transfer resumes with the stalled word.
- **Burst cap:** with `MAX_BURST` = 4, src0 sends a 10-word packet while src3 also requests.
  - Order: 4 words from src0, then src3's packet, then 4 words from src0, then src3 again if it is still requesting, then the final 2 words from src0.
- **Source bubble:** src1 drops req for 3 cycles mid-packet. The grant is held, no other source gets ready, and `w_req_o` = 0 during the gap.
- **Reset mid-operation:** pulse `rst_n_i` low during src2's packet.
  - All outputs go to 0 asynchronously.
  - After release, `rr_ptr` = 0, so src0 wins a simultaneous src0 and src2 request.
